// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA raster timing generator. Divides Clk by two into a pixel
//            strobe, scans horizontal/vertical counters across the full
//            line/frame, and decodes sync, blanking and frame markers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       Frame_start,
  output logic [7:0] Frame_count
);

  localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       pix_tick_q,    pix_tick_d;
  logic [9:0] h_cnt_q,       h_cnt_d;
  logic [9:0] v_cnt_q,       v_cnt_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  logic w_adv;
  logic w_h_wrap;
  logic w_v_wrap;

  // Pixel advance happens on the second Clk of each pixel period; the
  // ">=" compares let any out-of-range value fall back to zero.
  assign w_adv    = Enable & pix_tick_q;
  assign w_h_wrap = (h_cnt_q >= c_H_LAST);
  assign w_v_wrap = (v_cnt_q >= c_V_LAST);

  // Next-state logic for the pixel strobe, raster counters and frame markers.
  always_comb begin
    pix_tick_d    = pix_tick_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;

    if (Enable) begin
      pix_tick_d = ~pix_tick_q;
    end

    if (w_adv) begin
      if (w_h_wrap) begin
        h_cnt_d = 10'd0;
        if (w_v_wrap) begin
          v_cnt_d       = 10'd0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pix_tick_q    <= 1'b0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      pix_tick_q    <= pix_tick_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Sync and blanking decode purely from counter registers, so they only
  // move on Clk edges and never glitch from Enable.
  assign VGA_HS      = ~((h_cnt_q >= c_HS_START) && (h_cnt_q <= c_HS_END));
  assign VGA_VS      = ~((v_cnt_q >= c_VS_START) && (v_cnt_q <= c_VS_END));
  assign VGA_BLANK_N = (h_cnt_q < c_H_VIS) && (v_cnt_q < c_V_VIS);
  assign VGA_SYNC_N  = 1'b0;

  assign VGA_CLK     = pix_tick_q;
  assign DrawX       = h_cnt_q;
  assign DrawY       = v_cnt_q;
  assign Frame_start = frame_start_q;
  assign Frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Scoreboard bench for vga_timing_gen using a shrunken raster so
//            that hundreds of frames fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int TB_HV = 8;
  localparam int TB_HF = 2;
  localparam int TB_HS = 3;
  localparam int TB_HB = 3;
  localparam int TB_VV = 4;
  localparam int TB_VF = 1;
  localparam int TB_VS = 2;
  localparam int TB_VB = 1;
  localparam int TB_HT = TB_HV + TB_HF + TB_HS + TB_HB;   // 16
  localparam int TB_VT = TB_VV + TB_VF + TB_VS + TB_VB;   // 8
  localparam int TB_FT = 2 * TB_HT * TB_VT;               // Clk per frame

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Enable = 1'b0;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0] DrawX, DrawY;
  logic       Frame_start;
  logic [7:0] Frame_count;

  typedef struct {
    int h;
    int v;
    int pix;
    int fc;
    int fs;
  } exp_t;

  exp_t sb[$];
  int   ticks = 0;          // enabled Clk edges since last reset
  int   n_checks = 0;
  int   n_errors = 0;
  int   hs_low_f1 = 0;
  int   vs_low_f1 = 0;
  int   fs_pulses = 0;

  vga_timing_gen #(
    .H_VISIBLE(TB_HV), .H_FRONT(TB_HF), .H_SYNC(TB_HS), .H_BACK(TB_HB),
    .V_VISIBLE(TB_VV), .V_FRONT(TB_VF), .V_SYNC(TB_VS), .V_BACK(TB_VB)
  ) u_dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Enable      (Enable),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .Frame_start (Frame_start),
    .Frame_count (Frame_count)
  );

  always #10 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Current horizontal position according to the model.
  function automatic int cur_h();
    return (ticks / 2) % TB_HT;
  endfunction

  function automatic int cur_v();
    return ((ticks / 2) / TB_HT) % TB_VT;
  endfunction

  // Drive one Clk with the given Enable, predict the post-edge state from the
  // enabled-tick count, then compare once the edge has passed.
  task automatic cycle(input bit en);
    exp_t e;
    exp_t g;
    int   p;
    Enable = en;
    if (en) ticks++;
    p     = ticks / 2;
    e.pix = ticks % 2;
    e.h   = p % TB_HT;
    e.v   = (p / TB_HT) % TB_VT;
    e.fc  = (p / (TB_HT * TB_VT)) % 256;
    e.fs  = (en && (ticks % TB_FT == 0)) ? 1 : 0;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    g = sb.pop_front();
    check("drawx",  int'(DrawX),       g.h);
    check("drawy",  int'(DrawY),       g.v);
    check("vgaclk", int'(VGA_CLK),     g.pix);
    check("fcount", int'(Frame_count), g.fc);
    check("fstart", int'(Frame_start), g.fs);
    check("hs",     int'(VGA_HS),
          (g.h >= TB_HV + TB_HF && g.h < TB_HV + TB_HF + TB_HS) ? 0 : 1);
    check("vs",     int'(VGA_VS),
          (g.v >= TB_VV + TB_VF && g.v < TB_VV + TB_VF + TB_VS) ? 0 : 1);
    check("blank_n", int'(VGA_BLANK_N), (g.h < TB_HV && g.v < TB_VV) ? 1 : 0);
    check("sync_n", int'(VGA_SYNC_N),  0);
    if (g.fc == 1 && ticks <= 2 * TB_FT) begin
      if (!VGA_HS) hs_low_f1++;
      if (!VGA_VS) vs_low_f1++;
    end
    if (Frame_start) fs_pulses++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_drawx"},  int'(DrawX),       0);
    check({tag, "_drawy"},  int'(DrawY),       0);
    check({tag, "_hs"},     int'(VGA_HS),      1);
    check({tag, "_vs"},     int'(VGA_VS),      1);
    check({tag, "_blank"},  int'(VGA_BLANK_N), 1);
    check({tag, "_vgaclk"}, int'(VGA_CLK),     0);
    check({tag, "_sync"},   int'(VGA_SYNC_N),  0);
    check({tag, "_fs"},     int'(Frame_start), 0);
    check({tag, "_fc"},     int'(Frame_count), 0);
  endtask

  initial begin
    bit paused = 1'b0;

    // Reset is asserted from time zero; outputs must be clear before any edge.
    #5;
    check_reset_outputs("rst0");
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge Clk);
    Reset = 1'b1;

    // 257 frames with one Enable pause inside the first visible area.
    while (ticks < 257 * TB_FT) begin
      if (!paused && ticks < TB_FT && cur_h() == 5 && cur_v() == 3
          && ticks % 2 == 0) begin
        paused = 1'b1;
        repeat (50) cycle(1'b0);
      end
      cycle(1'b1);
    end
    check("pause_taken", int'(paused), 1);
    check("hs_low_frame1", hs_low_f1, 2 * TB_HS * TB_VT);
    check("vs_low_frame1", vs_low_f1, 2 * TB_VS * TB_HT);
    check("fs_pulses", fs_pulses, 257);

    // Move into the sync region of a line, then reset between Clk edges.
    for (int k = 0; k < 4 * TB_HT && !(cur_h() == TB_HV + TB_HF + 2
                                       && ticks % 2 == 0); k++) begin
      cycle(1'b1);
    end
    check("pre_rst_drawx", int'(DrawX), TB_HV + TB_HF + 2);
    check("pre_rst_hs",    int'(VGA_HS), 0);
    #4;
    Reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge Clk);
    #1;
    check_reset_outputs("rst_mid_hold");
    @(negedge Clk);
    Reset = 1'b1;
    ticks = 0;
    repeat (3 * TB_HT) cycle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels; H_TOTAL = sum of the four = 800.
REQ-005 SHALL have parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, vertical equivalents in lines; V_TOTAL = 525.
REQ-006 SHALL have port Clk  input  1  system clock, 50 MHz.
REQ-007 SHALL have port Reset  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port Enable  input  1  when 0, counters hold and pixel ticks are suppressed.
REQ-009 SHALL have port VGA_CLK  output  1  pixel clock, Clk/2, registered.
REQ-010 SHALL have port VGA_HS  output  1  horizontal sync, active-low.
REQ-011 SHALL have port VGA_VS  output  1  vertical sync, active-low.
REQ-012 SHALL have port VGA_BLANK_N  output  1  1 inside visible area.
REQ-013 SHALL have port VGA_SYNC_N  output  1  tied 0.
REQ-014 SHALL have port DrawX  output  10  current horizontal pixel count.
REQ-015 SHALL have port DrawY  output  10  current line count.
REQ-016 SHALL have port Frame_start  output  1  one-Clk pulse at frame wrap.
REQ-017 SHALL have port Frame_count  output  8  frames completed, wrapping.

Function
REQ-018 SHALL keep register pix_tick, toggling every Clk while Enable=1; VGA_CLK = pix_tick.
REQ-019 SHALL advance h_cnt only on Clk edges where pix_tick=1 and Enable=1 (one pixel per two Clk).
REQ-020 SHALL wrap h_cnt from H_TOTAL-1 to 0 and, on the same edge, increment v_cnt.
REQ-021 SHALL wrap v_cnt from V_TOTAL-1 to 0 when h_cnt wraps at v_cnt=V_TOTAL-1.
REQ-022 SHALL drive DrawX=h_cnt and DrawY=v_cnt directly from registers (full range 0..799 / 0..524 visible on ports).
REQ-023 SHALL drive VGA_HS=0 exactly for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751], else 1.
REQ-024 SHALL drive VGA_VS=0 exactly for v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490,491], else 1.
REQ-025 SHALL drive VGA_BLANK_N=1 iff h_cnt<H_VISIBLE and v_cnt<V_VISIBLE.
REQ-026 SHALL derive HS, VS, BLANK_N combinationally from counter registers only (no input dependency), so they change only on Clk edges.
REQ-027 SHALL assert Frame_start for exactly one Clk on the edge where h_cnt,v_cnt wrap to 0,0 (registered, high in the cycle counters read 0,0 and pix_tick=0).
REQ-028 SHALL increment Frame_count by 1 on the same edge as Frame_start rises, wrapping 255->0.
REQ-029 SHALL hold all counters, pix_tick and Frame_count unchanged while Enable=0, with Frame_start=0; resuming continues from held values.
REQ-030 SHALL treat counters as unsigned 10-bit; no value outside 0..H_TOTAL-1 / 0..V_TOTAL-1 reachable.

Reset
REQ-031 SHALL on Reset=0 immediately set h_cnt=0, v_cnt=0, pix_tick=0, Frame_count=0, Frame_start=0, independent of Clk.
REQ-032 SHALL therefore present DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=1, VGA_CLK=0, VGA_SYNC_N=0 during reset.
REQ-033 SHALL, after release, advance h_cnt first on the second Clk rising edge (first edge sets pix_tick=1); reset mid-frame restarts at 0,0 with no Frame_start pulse.

Verification
REQ-034 Release reset, Enable=1, run 1600 Clk -> DrawX counts 0..799 each value held 2 Clk, DrawY increments 0->1 at wrap.
REQ-035 Run one line -> VGA_HS low for exactly 192 Clk, first low when DrawX=656; BLANK_N low from DrawX=640 to 799.
REQ-036 Run full frame (840000 Clk) -> VGA_VS low for exactly 2 lines (3200 Clk) at DrawY 490-491; Frame_start single 1-Clk pulse, Frame_count 0->1.
REQ-037 Run 256 frames -> Frame_count wraps 255->0 with Frame_start still pulsing.
REQ-038 Deassert Enable at DrawX=100,DrawY=200 for 50 Clk -> DrawX/DrawY/VGA_CLK frozen, no Frame_start; resume continues at 101.
REQ-039 Assert Reset asynchronously mid-line at DrawX=700 between Clk edges -> DrawX=0,DrawY=0,HS=1 immediately; no Frame_start, Frame_count=0.
